// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction controller.
// Holds the FSM state encoding, the bit positions inside the latched mode
// register, and the default frame/divider constants.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    // Latched mode register layout: {CPOL, CPHA}
    localparam int MODE_CPHA_BIT = 0;
    localparam int MODE_CPOL_BIT = 1;

    localparam int DEF_D_PACK  = 8;
    localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host request/response and SPI pin bundle for spi_master_ctrl.
//   START/CPOL/CPHA/TX_DATA : host request, sampled when the controller is idle
//   BUSY/DONE/RX_DATA       : host status and received word
//   SCLK/CS_N/MOSI          : pins driven by the controller
//   MISO                    : pin driven by the attached slave device
// master : host and slave-device side (drives requests and MISO)
// slave  : the controller itself
interface spi_master_ctrl_if #(
    parameter int D_PACK = 8
) ();
    logic              START;
    logic              CPOL;
    logic              CPHA;
    logic [D_PACK-1:0] TX_DATA;
    logic              MISO;
    logic              SCLK;
    logic              CS_N;
    logic              MOSI;
    logic              BUSY;
    logic              DONE;
    logic [D_PACK-1:0] RX_DATA;

    modport master (
        output START, CPOL, CPHA, TX_DATA, MISO,
        input  SCLK, CS_N, MOSI, BUSY, DONE, RX_DATA
    );

    modport slave (
        input  START, CPOL, CPHA, TX_DATA, MISO,
        output SCLK, CS_N, MOSI, BUSY, DONE, RX_DATA
    );
endinterface

// File: rtl/spi_shift_reg.sv
// Full-duplex SPI shifter.
//   load/load_data : parallel load of the word to send
//   shift          : shift left one place, MSB leaves on mosi, the last
//                    sampled MISO bit enters at the LSB
//   sample         : capture miso into the one-bit sample stage
//   mosi           : current MSB (registered)
//   rx_word        : received word assuming the final sample has been taken
// Sampling and shifting always happen on different SCLK edges, so the
// sample stage holds each bit until the next shift pushes it in. The last
// sampled bit is never shifted; rx_word appends it directly.
module spi_shift_reg #(
    parameter int D_PACK = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic              shift,
    input  logic              sample,
    input  logic              miso,
    input  logic [D_PACK-1:0] load_data,
    output logic              mosi,
    output logic [D_PACK-1:0] rx_word
);
    logic [D_PACK-1:0] sr_q, sr_d;
    logic              smp_q, smp_d;

    always_comb begin
        sr_d  = sr_q;
        smp_d = smp_q;
        if (load) begin
            sr_d = load_data;
        end else if (shift) begin
            sr_d = {sr_q[D_PACK-2:0], smp_q};
        end
        if (sample) begin
            smp_d = miso;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr_q  <= '0;
            smp_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            smp_q <= smp_d;
        end
    end

    assign mosi    = sr_q[D_PACK-1];
    assign rx_word = {sr_q[D_PACK-2:0], smp_q};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI transaction controller: one D_PACK-bit full-duplex transfer per
// accepted START, all four CPOL/CPHA modes, MSB first.
//   CLK, RST : system clock, asynchronous active-high reset
//   bus      : host request/status and SPI pins (see spi_master_ctrl_if)
// Frame timing, H = CLK_DIV: CS_N low H cycles (LEAD), then 2*D_PACK SCLK
// half-periods of H cycles each with a toggle at the start of each one
// (XFER), then H idle cycles (TRAIL). CS_N rises together with DONE.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int D_PACK  = DEF_D_PACK,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic             CLK,
    input  logic             RST,
    spi_master_ctrl_if.slave bus
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * D_PACK);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * D_PACK - 1);

    spi_state_e        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [1:0]        mode_q, mode_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [D_PACK-1:0] rx_q, rx_d;

    logic              tick;
    logic              toggle;
    logic [EDGE_W-1:0] nxt_edge;
    logic              lead_edge;
    logic              first_edge;
    logic              last_edge;
    logic              cpha;
    logic              sr_load;
    logic              sr_shift;
    logic              sr_sample;
    logic [D_PACK-1:0] rx_word;

    assign cpha = mode_q[MODE_CPHA_BIT];
    assign tick = (div_q == DIV_LAST);

    // Toggle index about to be produced: the LEAD->XFER tick makes toggle 0,
    // every later non-final XFER tick makes edge_q+1. The tick ending the
    // last half-period only hands over to TRAIL.
    assign nxt_edge   = (state_q == LEAD) ? '0 : edge_q + EDGE_W'(1);
    assign toggle     = tick && ((state_q == LEAD) ||
                                 ((state_q == XFER) && (edge_q != EDGE_LAST)));
    assign lead_edge  = ~nxt_edge[0];
    assign first_edge = (nxt_edge == '0);
    assign last_edge  = (nxt_edge == EDGE_LAST);

    // CPHA=0: sample on leading, shift on trailing (not the last one).
    // CPHA=1: shift on leading (not the first one), sample on trailing.
    assign sr_load   = (state_q == IDLE) && bus.START;
    assign sr_sample = toggle && (cpha ? ~lead_edge : lead_edge);
    assign sr_shift  = toggle && (cpha ? (lead_edge & ~first_edge)
                                       : (~lead_edge & ~last_edge));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        edge_d  = edge_q;
        mode_d  = mode_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rx_d    = rx_q;
        case (state_q)
            IDLE: begin
                div_d  = '0;
                edge_d = '0;
                if (bus.START) begin
                    mode_d[MODE_CPOL_BIT] = bus.CPOL;
                    mode_d[MODE_CPHA_BIT] = bus.CPHA;
                    sclk_d  = bus.CPOL;
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LEAD;
                end
            end
            LEAD, XFER: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (toggle) begin
                    sclk_d = ~sclk_q;
                    edge_d = nxt_edge;
                end
                if (tick) begin
                    if (state_q == LEAD) begin
                        state_d = XFER;
                    end else if (edge_q == EDGE_LAST) begin
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                div_d = tick ? '0 : div_q + DIV_W'(1);
                if (tick) begin
                    state_d = IDLE;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    rx_d    = rx_word;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            mode_q  <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            edge_q  <= edge_d;
            mode_q  <= mode_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
        end
    end

    spi_shift_reg #(.D_PACK(D_PACK)) u_shift (
        .CLK       (CLK),
        .RST       (RST),
        .load      (sr_load),
        .shift     (sr_shift),
        .sample    (sr_sample),
        .miso      (bus.MISO),
        .load_data (bus.TX_DATA),
        .mosi      (bus.MOSI),
        .rx_word   (rx_word)
    );

    assign bus.SCLK    = sclk_q;
    assign bus.CS_N    = cs_n_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.RX_DATA = rx_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a default instance (8 bits, H=4) with a
// loopback / slave-device MISO source, and a 16-bit H=1 instance in loopback.
module tb_spi_master_ctrl;
    import spi_pkg::*;

    localparam int D       = 8;
    localparam int H       = 4;
    localparam int D2      = 16;
    localparam int H2      = 1;
    localparam int CS_LEN  = (2 * D + 2) * H;
    localparam int CS_LEN2 = (2 * D2 + 2) * H2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    spi_master_ctrl_if #(.D_PACK(D))  bus  ();
    spi_master_ctrl_if #(.D_PACK(D2)) bus2 ();

    spi_master_ctrl #(.D_PACK(D),  .CLK_DIV(H))  dut  (.CLK(CLK), .RST(RST), .bus(bus.slave));
    spi_master_ctrl #(.D_PACK(D2), .CLK_DIV(H2)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // MISO source: loopback of MOSI or a slave-device model
    logic         loop_en  = 1'b1;
    logic         slv_miso = 1'b0;
    logic [D-1:0] slv_word = '0;
    logic         cur_cpol = 1'b0;
    logic         cur_cpha = 1'b0;
    assign bus.MISO  = loop_en ? bus.MOSI : slv_miso;
    assign bus2.MISO = bus2.MOSI;

    logic [D-1:0]  exp_q[$];
    logic [D-1:0]  tx_q[$];
    logic [D2-1:0] exp2_q[$];

    // ---------------- monitor / slave model, instance 1 ----------------
    logic         p_cs_n = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
    int           cs_len = 0, gap_cnt = 0, last_gap = 0, sclk_edges = 0;
    int           mosi_bad = 0, busy_bad = 0, done_cnt = 0, slv_idx = 0;
    logic [D-1:0] slv_rx = '0;
    logic         lead;

    always @(negedge CLK) begin
        if (RST) begin
            p_cs_n = 1'b1;
            p_sclk = 1'b0;
            p_mosi = 1'b0;
        end else begin
            if (bus.BUSY !== ~bus.CS_N) busy_bad++;
            if (bus.CS_N === 1'b0 && p_cs_n === 1'b1) begin
                last_gap = gap_cnt; gap_cnt = 0; cs_len = 1; sclk_edges = 0;
                mosi_bad = 0; slv_rx = '0; slv_idx = D - 1;
                if (!cur_cpha) slv_miso = slv_word[D-1];
            end else if (bus.CS_N === 1'b0) begin
                cs_len++;
                lead = (bus.SCLK != cur_cpol);
                if (bus.MOSI !== p_mosi && (bus.SCLK === p_sclk || lead != cur_cpha)) mosi_bad++;
                if (bus.SCLK !== p_sclk) begin
                    sclk_edges++;
                    if (lead) begin
                        if (cur_cpha) begin
                            if (slv_idx >= 0) slv_miso = slv_word[slv_idx];
                            slv_idx--;
                        end else begin
                            slv_rx = {slv_rx[D-2:0], bus.MOSI};
                        end
                    end else begin
                        if (cur_cpha) begin
                            slv_rx = {slv_rx[D-2:0], bus.MOSI};
                        end else begin
                            slv_idx--;
                            if (slv_idx >= 0) slv_miso = slv_word[slv_idx];
                        end
                    end
                end
            end else begin
                gap_cnt++;
            end
            if (bus.DONE === 1'b1) begin
                done_cnt++;
                chk("done_cs_n", 32'(bus.CS_N), 32'd1);
                chk("cs_len", cs_len, CS_LEN);
                chk("sclk_edges", sclk_edges, 2 * D);
                chk("mosi_stable", mosi_bad, 0);
                chk("done_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("rx_data", 32'(bus.RX_DATA), 32'(exp_q.pop_front()));
                    chk("slave_rx", 32'(slv_rx), 32'(tx_q.pop_front()));
                end
            end
            p_cs_n = bus.CS_N;
            p_sclk = bus.SCLK;
            p_mosi = bus.MOSI;
        end
    end

    // ---------------- monitor, instance 2 ----------------
    logic p2_cs = 1'b1, p2_sclk = 1'b0;
    int   cs2_len = 0, tog2 = 0, hp_bad2 = 0, last_tog = -1, cyc2 = 0, done2 = 0;

    always @(negedge CLK) begin
        if (RST) begin
            p2_cs   = 1'b1;
            p2_sclk = 1'b0;
        end else begin
            if (bus2.CS_N === 1'b0 && p2_cs === 1'b1) begin
                cs2_len = 1; tog2 = 0; hp_bad2 = 0; last_tog = -1; cyc2 = 0;
            end else if (bus2.CS_N === 1'b0) begin
                cs2_len++;
                cyc2++;
                if (bus2.SCLK !== p2_sclk) begin
                    tog2++;
                    if (last_tog >= 0 && cyc2 - last_tog != H2) hp_bad2++;
                    last_tog = cyc2;
                end
            end
            if (bus2.DONE === 1'b1) begin
                done2++;
                chk("cs_len_16", cs2_len, CS_LEN2);
                chk("sclk_toggles_16", tog2, 2 * D2);
                chk("sclk_period_16", hp_bad2, 0);
                chk("done_expected_16", 32'(exp2_q.size() > 0), 32'd1);
                if (exp2_q.size() > 0) chk("rx_data_16", 32'(bus2.RX_DATA), 32'(exp2_q.pop_front()));
            end
            p2_cs   = bus2.CS_N;
            p2_sclk = bus2.SCLK;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic xfer_start(input logic pol, input logic pha,
                              input logic [D-1:0] tx, input logic [D-1:0] slv);
        @(negedge CLK);
        cur_cpol = pol; cur_cpha = pha; slv_word = slv;
        bus.CPOL = pol; bus.CPHA = pha; bus.TX_DATA = tx; bus.START = 1'b1;
        exp_q.push_back(loop_en ? tx : slv);
        tx_q.push_back(tx);
        @(negedge CLK);
        bus.START = 1'b0;
        chk("cs_fall", 32'(bus.CS_N), 32'd0);
        chk("busy_rise", 32'(bus.BUSY), 32'd1);
        chk("lead_sclk", 32'(bus.SCLK), 32'(pol));
        chk("lead_mosi", 32'(bus.MOSI), 32'(tx[D-1]));
        // request inputs must be ignored for the rest of the frame
        bus.TX_DATA = ~tx; bus.CPOL = ~pol; bus.CPHA = ~pha;
    endtask

    task automatic wait_done(input int lim);
        int n0;
        int k;
        n0 = done_cnt;
        k  = 0;
        while (done_cnt == n0 && k < lim) begin
            @(negedge CLK);
            k++;
        end
        chk("done_timeout", 32'(done_cnt != n0), 32'd1);
    endtask

    int           n0;
    logic [D-1:0] rtx, rslv;

    initial begin
        bus.START = 1'b0; bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.TX_DATA = '0;
        bus2.START = 1'b0; bus2.CPOL = 1'b0; bus2.CPHA = 1'b0; bus2.TX_DATA = '0;

        // reset state
        repeat (3) @(negedge CLK);
        chk("rst_cs_n", 32'(bus.CS_N), 32'd1);
        chk("rst_sclk", 32'(bus.SCLK), 32'd0);
        chk("rst_mosi", 32'(bus.MOSI), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_rx", 32'(bus.RX_DATA), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // mode 0, loopback 0xA5
        loop_en = 1'b1;
        n0 = done_cnt;
        xfer_start(1'b0, 1'b0, 8'hA5, 8'h00);
        wait_done(200);
        @(negedge CLK);
        chk("done_pulse", 32'(bus.DONE), 32'd0);
        chk("idle_sclk_m0", 32'(bus.SCLK), 32'd0);
        chk("done_count_m0", done_cnt - n0, 1);

        // mode 3, slave model sends 0xC3, master sends 0x3C; then random word
        loop_en = 1'b0;
        xfer_start(1'b1, 1'b1, 8'h3C, 8'hC3);
        wait_done(200);
        @(negedge CLK);
        chk("idle_sclk_m3_after", 32'(bus.SCLK), 32'd1);
        rtx = 8'($urandom); rslv = 8'($urandom);
        xfer_start(1'b1, 1'b1, rtx, rslv);
        wait_done(200);

        // all four modes with the slave model and random data
        for (int m = 0; m < 4; m++) begin
            rtx = 8'($urandom); rslv = 8'($urandom);
            xfer_start(m[1], m[0], rtx, rslv);
            wait_done(200);
        end

        // START pulses at cycles 10 and 30 of an active frame are ignored
        loop_en = 1'b1;
        n0 = done_cnt;
        xfer_start(1'b0, 1'b0, 8'h5A, 8'h00);
        repeat (9) @(negedge CLK);
        bus.TX_DATA = 8'hFF; bus.START = 1'b1;
        @(negedge CLK); bus.START = 1'b0;
        repeat (19) @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK); bus.START = 1'b0;
        wait_done(200);
        repeat (100) @(negedge CLK);
        chk("done_count_ignored_start", done_cnt - n0, 1);
        chk("busy_vs_cs", busy_bad, 0);

        // reset at cycle 20 of a mode-3 frame
        n0 = done_cnt;
        xfer_start(1'b1, 1'b1, 8'h77, 8'h00);
        repeat (19) @(negedge CLK);
        @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("abort_cs_n", 32'(bus.CS_N), 32'd1);
        chk("abort_sclk", 32'(bus.SCLK), 32'd0);
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        chk("abort_rx", 32'(bus.RX_DATA), 32'd0);
        chk("abort_done", 32'(bus.DONE), 32'd0);
        exp_q.delete();
        tx_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        repeat (120) @(negedge CLK);
        chk("abort_no_done", done_cnt - n0, 0);
        xfer_start(1'b0, 1'b0, 8'h96, 8'h00);
        wait_done(200);

        // START held through DONE: back-to-back frames, one-cycle CS_N gap
        n0 = done_cnt;
        @(negedge CLK);
        cur_cpol = 1'b0; cur_cpha = 1'b0;
        bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.TX_DATA = 8'h81; bus.START = 1'b1;
        exp_q.push_back(8'h81); tx_q.push_back(8'h81);
        exp_q.push_back(8'h81); tx_q.push_back(8'h81);
        wait_done(200);
        @(posedge CLK);
        #1 bus.START = 1'b0;
        wait_done(200);
        chk("cs_gap", last_gap, 1);
        chk("done_count_b2b", done_cnt - n0, 2);
        chk("busy_vs_cs_end", busy_bad, 0);

        // 16-bit, H=1, mode 1, loopback 0xBEEF
        n0 = done2;
        @(negedge CLK);
        bus2.CPOL = 1'b0; bus2.CPHA = 1'b1; bus2.TX_DATA = 16'hBEEF; bus2.START = 1'b1;
        exp2_q.push_back(16'hBEEF);
        @(negedge CLK);
        bus2.START = 1'b0;
        for (int k = 0; k < 100 && done2 == n0; k++) @(negedge CLK);
        chk("done_timeout_16", done2 - n0, 1);

        repeat (4) @(negedge CLK);
        chk("queue_drained", 32'(exp_q.size() + exp2_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
